// File: rtl/cla_generator_if.sv
// Operand/result bundle for cla_generator.
// The master drives the operands and the slave (the adder) returns the registered result.
interface cla_generator_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_carry;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;

  modport master (
    output in_a,
    output in_b,
    output in_carry,
    input  out_sum,
    input  out_carry
  );

  modport slave (
    input  in_a,
    input  in_b,
    input  in_carry,
    output out_sum,
    output out_carry
  );
endinterface

// File: rtl/cla_generator.sv
// Carry-lookahead adder with a registered result stage.
// The adder is built from 4-bit groups, and a flat lookahead unit computes the group carries.
module cla_generator #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  cla_generator_if.slave bus
);
  localparam int NGRP = WIDTH / 4;

  generate
    if ((WIDTH % 4 != 0) || (WIDTH < 4) || (WIDTH > 64)) begin : g_bad_width
      $error("cla_generator: WIDTH must be a multiple of 4 in 4..64");
    end
    if ($bits(bus.in_a) != WIDTH) begin : g_bad_bus
      $error("cla_generator: interface WIDTH does not match adder WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] c_s;
  logic [WIDTH-1:0] sum_s;
  logic [NGRP-1:0]  grp_p_s;
  logic [NGRP-1:0]  grp_g_s;
  logic [NGRP:0]    grp_c_s;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;

  assign p_s = bus.in_a ^ bus.in_b;
  assign g_s = bus.in_a & bus.in_b;

  // Each group expands its carries as sum-of-products of the group carry-in.
  for (genvar k = 0; k < NGRP; k++) begin : g_group
    localparam int B = 4 * k;
    logic cg_s;
    assign cg_s       = grp_c_s[k];
    assign c_s[B]     = cg_s;
    assign c_s[B + 1] = g_s[B] | (p_s[B] & cg_s);
    assign c_s[B + 2] = g_s[B + 1] | (p_s[B + 1] & g_s[B])
                      | (p_s[B + 1] & p_s[B] & cg_s);
    assign c_s[B + 3] = g_s[B + 2] | (p_s[B + 2] & g_s[B + 1])
                      | (p_s[B + 2] & p_s[B + 1] & g_s[B])
                      | (p_s[B + 2] & p_s[B + 1] & p_s[B] & cg_s);
    assign grp_p_s[k] = p_s[B + 3] & p_s[B + 2] & p_s[B + 1] & p_s[B];
    assign grp_g_s[k] = g_s[B + 3] | (p_s[B + 3] & g_s[B + 2])
                      | (p_s[B + 3] & p_s[B + 2] & g_s[B + 1])
                      | (p_s[B + 3] & p_s[B + 2] & p_s[B + 1] & g_s[B]);
  end

  // Lookahead unit: every group carry is an independent OR of P/G product terms.
  always_comb begin : lookahead_comb
    logic acc_s;
    logic pand_s;
    acc_s      = 1'b0;
    pand_s     = 1'b1;
    grp_c_s    = '0;
    grp_c_s[0] = bus.in_carry;
    for (int k = 1; k <= NGRP; k++) begin
      acc_s  = 1'b0;
      pand_s = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        acc_s  = acc_s | (grp_g_s[j] & pand_s);
        pand_s = pand_s & grp_p_s[j];
      end
      grp_c_s[k] = acc_s | (pand_s & bus.in_carry);
    end
  end

  assign sum_s = p_s ^ c_s;

  // Result register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r   <= '0;
      carry_r <= 1'b0;
    end else begin
      sum_r   <= sum_s;
      carry_r <= grp_c_s[NGRP];
    end
  end

  assign bus.out_sum   = sum_r;
  assign bus.out_carry = carry_r;
endmodule

// File: tb/tb_cla_generator.sv
// Directed and swept checks of cla_generator at WIDTH 32, 4 and 64.
module tb_cla_generator;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cla_generator_if #(.WIDTH(32)) bus32 ();
  cla_generator_if #(.WIDTH(4))  bus4 ();
  cla_generator_if #(.WIDTH(64)) bus64 ();

  cla_generator #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  cla_generator #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  cla_generator #(.WIDTH(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64.slave));

  int checks = 0;
  int failures = 0;

  task automatic check_result(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic c);
    bus32.in_a     = a;
    bus32.in_b     = b;
    bus32.in_carry = c;
  endtask

  function automatic logic [64:0] res32();
    return {32'd0, bus32.out_carry, bus32.out_sum};
  endfunction

  logic [31:0] dir_a [8];
  logic [31:0] dir_b [8];
  logic        dir_c [8];
  logic [32:0] dir_e [8];

  initial begin
    logic [32:0] exp_prev;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [63:0] wa;
    logic [63:0] wb;
    logic [3:0]  na;
    logic [3:0]  nb;

    // Hand-computed directed vectors
    dir_a[0] = 32'hFFFFFFFF; dir_b[0] = 32'h00000000; dir_c[0] = 1'b1; dir_e[0] = {1'b1, 32'h00000000};
    dir_a[1] = 32'hFFFFFFFF; dir_b[1] = 32'hFFFFFFFF; dir_c[1] = 1'b1; dir_e[1] = {1'b1, 32'hFFFFFFFF};
    dir_a[2] = 32'h12345678; dir_b[2] = 32'h0000000F; dir_c[2] = 1'b0; dir_e[2] = {1'b0, 32'h12345687};
    dir_a[3] = 32'h0000FFFF; dir_b[3] = 32'h00000001; dir_c[3] = 1'b0; dir_e[3] = {1'b0, 32'h00010000};
    dir_a[4] = 32'h80000000; dir_b[4] = 32'h80000000; dir_c[4] = 1'b0; dir_e[4] = {1'b1, 32'h00000000};
    dir_a[5] = 32'h0F0F0F0F; dir_b[5] = 32'hF0F0F0F0; dir_c[5] = 1'b1; dir_e[5] = {1'b1, 32'h00000000};
    dir_a[6] = 32'h7FFFFFFF; dir_b[6] = 32'h00000000; dir_c[6] = 1'b1; dir_e[6] = {1'b0, 32'h80000000};
    dir_a[7] = 32'h00000000; dir_b[7] = 32'h00000000; dir_c[7] = 1'b0; dir_e[7] = {1'b0, 32'h00000000};

    rst_n = 1'b0;
    drive32(32'hFFFFFFFF, 32'h00000001, 1'b0);
    bus4.in_a = 4'hF; bus4.in_b = 4'h1; bus4.in_carry = 1'b1;
    bus64.in_a = 64'hFFFFFFFFFFFFFFFF; bus64.in_b = 64'h1; bus64.in_carry = 1'b1;

    // Outputs stay cleared while reset is held, across clock edges
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_result("reset_hold_pos", res32(), 65'd0);
      @(negedge clk);
      check_result("reset_hold_neg", res32(), 65'd0);
    end
    check_result("reset_w4", {60'd0, bus4.out_carry, bus4.out_sum}, 65'd0);
    check_result("reset_w64", {bus64.out_carry, bus64.out_sum}, 65'd0);
    rst_n = 1'b1;

    // Directed vectors, one cycle latency each
    for (int i = 0; i < 8; i++) begin
      drive32(dir_a[i], dir_b[i], dir_c[i]);
      @(negedge clk);
      check_result($sformatf("directed_%0d", i), res32(), {32'd0, dir_e[i]});
    end

    // Back-to-back random stream; outputs follow the previous cycle's inputs
    exp_prev = '0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) check_result($sformatf("stream_%0d", i), res32(), {32'd0, exp_prev});
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      drive32(ra, rb, rc);
      exp_prev = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      @(negedge clk);
    end
    check_result("stream_last", res32(), {32'd0, exp_prev});

    // Asynchronous reset mid-stream clears outputs before the next edge
    drive32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    check_result("pre_reset_value", res32(), {32'd0, 1'b1, 32'hFFFFFFFF});
    drive32(32'h11111111, 32'h22222222, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_result("async_clear", res32(), 65'd0);
    @(negedge clk);
    check_result("reset_discard", res32(), 65'd0);
    rst_n = 1'b1;
    drive32(32'h00000005, 32'h00000003, 1'b1);
    @(negedge clk);
    check_result("post_reset_first", res32(), {32'd0, 33'h000000009});

    // WIDTH=4 exhaustive sweep
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          na = 4'(a); nb = 4'(b);
          bus4.in_a = na; bus4.in_b = nb; bus4.in_carry = 1'(c);
          @(negedge clk);
          check_result($sformatf("w4_%0d_%0d_%0d", a, b, c),
                       {60'd0, bus4.out_carry, bus4.out_sum}, 65'(a + b + c));
        end
      end
    end

    // WIDTH=64 random sweep
    for (int i = 0; i < 1000; i++) begin
      wa = {$urandom, $urandom}; wb = {$urandom, $urandom}; rc = 1'($urandom_range(0, 1));
      if (i == 0) begin wa = 64'hFFFFFFFFFFFFFFFF; wb = 64'h0; rc = 1'b1; end
      bus64.in_a = wa; bus64.in_b = wb; bus64.in_carry = rc;
      @(negedge clk);
      check_result($sformatf("w64_%0d", i), {bus64.out_carry, bus64.out_sum},
                   {1'b0, wa} + {1'b0, wb} + {64'd0, rc});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
